// File: rtl/fp_int_converter.sv
// Registered float <-> signed fixed-point (R fraction bits) converter.
// Two independent single-stage paths: fp2int and int2fp.
module fp_int_converter #(
    parameter int I_EXP  = 8,
    parameter int I_MNT  = 23,
    parameter int I_DATA = 32,
    parameter int R      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [I_DATA-1:0] fp_in,
    output logic [I_DATA-1:0] int_out,
    output logic              int_valid,
    input  logic              int_enable,
    input  logic [I_DATA-1:0] int_in,
    output logic [I_DATA-1:0] fp_out,
    output logic              fp_valid
);
    localparam int BIAS = 2**(I_EXP-1) - 1;
    localparam int EMAX = BIAS + I_DATA - 1 - R;
    localparam int SW   = I_EXP + 3;
    localparam int PW   = $clog2(I_DATA + 1);
    localparam logic signed [SW-1:0] SH_OFF = SW'(R - I_MNT - BIAS);

    logic [I_DATA-1:0]     int_d, int_q, fp_d, fp_q;
    logic                  int_vld_q, fp_vld_q;

    logic                  f_s;
    logic [I_EXP-1:0]      f_e;
    logic [I_MNT-1:0]      f_m;
    logic signed [SW-1:0]  f_sh;
    logic [I_DATA-1:0]     f_mant, f_mag;

    logic                  i_s;
    logic [I_DATA:0]       i_mag, i_norm;
    logic [PW-1:0]         i_p;
    logic [I_EXP-1:0]      i_e;
    logic                  unused_bits;

    // fp2int: barrel shift {1,mnt} by (exp - bias + R - I_MNT)
    always_comb begin
        f_s    = fp_in[I_DATA-1];
        f_e    = fp_in[I_DATA-2 -: I_EXP];
        f_m    = fp_in[I_MNT-1:0];
        f_sh   = $signed(SW'(f_e)) + SH_OFF;
        f_mant = {{(I_DATA-I_MNT-1){1'b0}}, 1'b1, f_m};
        f_mag  = '0;
        if (!f_sh[SW-1]) f_mag = f_mant << f_sh;
        else             f_mag = f_mant >> (-f_sh);
        int_d = f_s ? -f_mag : f_mag;
        if (f_e == '0)
            int_d = '0;
        else if (f_e == '1 && f_m != '0)
            int_d = '0;
        else if (int'(f_e) >= EMAX)
            int_d = f_s ? {1'b1, {(I_DATA-1){1'b0}}} : {1'b0, {(I_DATA-1){1'b1}}};
    end

    // int2fp: magnitude in I_DATA+1 bits so the most negative input has a magnitude
    always_comb begin
        i_s   = int_in[I_DATA-1];
        i_mag = i_s ? ((I_DATA+1)'(0) - {1'b1, int_in}) : {1'b0, int_in};
        i_p   = '0;
        for (int i = 0; i <= I_DATA; i++)
            if (i_mag[i]) i_p = PW'(i);
        i_norm = i_mag << (PW'(I_DATA) - i_p);
        i_e    = I_EXP'(int'(i_p) + BIAS - R);
        fp_d   = (i_mag == '0) ? '0 : {i_s, i_e, i_norm[I_DATA-1 -: I_MNT]};
    end

    assign unused_bits = ^{i_norm[I_DATA], i_norm[I_DATA-I_MNT-1:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            int_q     <= '0;
            int_vld_q <= 1'b0;
            fp_q      <= '0;
            fp_vld_q  <= 1'b0;
        end else begin
            int_vld_q <= enable;
            fp_vld_q  <= int_enable;
            if (enable)     int_q <= int_d;
            if (int_enable) fp_q  <= fp_d;
        end
    end

    assign int_out   = int_q;
    assign int_valid = int_vld_q;
    assign fp_out    = fp_q;
    assign fp_valid  = fp_vld_q;
endmodule

// File: tb/tb_fp_int_converter.sv
// Directed bench for fp_int_converter: reset, known vectors, saturation,
// int2fp edges, and a 100-sample looped-back round-trip stream.
module tb_fp_int_converter;
    logic        clk = 1'b0;
    logic        reset, enable, int_en_r, loop;
    logic [31:0] fp_in, int_in_r;
    logic [31:0] int_out, fp_out, int_in_w;
    logic        int_valid, fp_valid, int_enable_w;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] vals [100];

    always #5 clk = ~clk;

    assign int_in_w     = loop ? int_out   : int_in_r;
    assign int_enable_w = loop ? int_valid : int_en_r;

    fp_int_converter dut (
        .clk(clk), .reset(reset), .enable(enable), .fp_in(fp_in),
        .int_out(int_out), .int_valid(int_valid),
        .int_enable(int_enable_w), .int_in(int_in_w),
        .fp_out(fp_out), .fp_valid(fp_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Exact Q16.16 value of a float with exponent 134..141
    function automatic logic [31:0] q16(input logic [31:0] f);
        logic [31:0] m;
        m = {8'h0, 1'b1, f[22:0]} << (f[30:23] - 8'd134);
        return f[31] ? -m : m;
    endfunction

    logic [31:0] sat_in  [6] = '{32'h47800000, 32'hC7800000, 32'h7F800000,
                                 32'h7FC00000, 32'h35800000, 32'hC7000000};
    logic [31:0] sat_exp [6] = '{32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                                 32'h00000000, 32'h00000000, 32'h80000000};
    logic [31:0] i2f_in  [4] = '{32'h7FFFFFFF, 32'h80000000, 32'h00000001, 32'h00000000};
    logic [31:0] i2f_exp [4] = '{32'h46FFFFFF, 32'hC7000000, 32'h37800000, 32'h00000000};

    initial begin
        loop = 1'b0; reset = 1'b0; enable = 1'b1; int_en_r = 1'b1;
        fp_in = 32'h3F800000; int_in_r = 32'h00010000;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_int_out", int_out, 32'h0);
            chk("rst_fp_out", fp_out, 32'h0);
            chk("rst_int_valid", {31'h0, int_valid}, 32'h0);
            chk("rst_fp_valid", {31'h0, fp_valid}, 32'h0);
        end
        reset = 1'b1;
        tick();
        chk("one_int", int_out, 32'h00010000);
        chk("one_int_valid", {31'h0, int_valid}, 32'h1);
        chk("one_fp", fp_out, 32'h3F800000);
        chk("one_fp_valid", {31'h0, fp_valid}, 32'h1);

        fp_in = 32'hC0200000; int_en_r = 1'b0;
        tick();
        chk("m25_int", int_out, 32'hFFFD8000);
        chk("m25_int_valid", {31'h0, int_valid}, 32'h1);
        chk("m25_fp_valid_lo", {31'h0, fp_valid}, 32'h0);
        chk("m25_fp_hold", fp_out, 32'h3F800000);
        enable = 1'b0; int_en_r = 1'b1; int_in_r = 32'hFFFD8000;
        tick();
        chk("m25_int_valid_lo", {31'h0, int_valid}, 32'h0);
        chk("m25_int_hold", int_out, 32'hFFFD8000);
        chk("m25_fp", fp_out, 32'hC0200000);
        chk("m25_fp_valid", {31'h0, fp_valid}, 32'h1);

        enable = 1'b1; int_en_r = 1'b0;
        for (int i = 0; i < 6; i++) begin
            fp_in = sat_in[i];
            tick();
            chk($sformatf("sat%0d", i), int_out, sat_exp[i]);
        end
        enable = 1'b0; int_en_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int_in_r = i2f_in[i];
            tick();
            chk($sformatf("i2f%0d", i), fp_out, i2f_exp[i]);
        end
        int_en_r = 1'b0;
        tick();
        chk("idle_fp_valid", {31'h0, fp_valid}, 32'h0);

        for (int i = 0; i < 100; i++)
            vals[i] = {1'(($urandom & 1)), 8'(134 + $urandom_range(0, 7)), 23'($urandom)};
        loop = 1'b1;
        for (int k = 0; k < 103; k++) begin
            if (k < 100) begin
                enable = 1'b1; fp_in = vals[k];
            end else begin
                enable = 1'b0; fp_in = 32'hDEADBEEF;
            end
            tick();
            if (k < 100) begin
                chk($sformatf("str_int%0d", k), int_out, q16(vals[k]));
                chk($sformatf("str_int_valid%0d", k), {31'h0, int_valid}, 32'h1);
            end else begin
                chk($sformatf("str_int_valid_lo%0d", k), {31'h0, int_valid}, 32'h0);
                chk($sformatf("str_int_hold%0d", k), int_out, q16(vals[99]));
            end
            if (k == 0)
                chk("str_fp_valid_first", {31'h0, fp_valid}, 32'h0);
            else if (k <= 100) begin
                chk($sformatf("str_fp%0d", k), fp_out, vals[k-1]);
                chk($sformatf("str_fp_valid%0d", k), {31'h0, fp_valid}, 32'h1);
            end else begin
                chk($sformatf("str_fp_valid_lo%0d", k), {31'h0, fp_valid}, 32'h0);
                chk($sformatf("str_fp_hold%0d", k), fp_out, vals[99]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fp_int_converter.md
Name: fp_int_converter

Overview:
- Bidirectional, registered converter between IEEE-754-style floating point (sign/exponent/mantissa) and signed two's-complement fixed point with R fraction bits.
- Two independent single-stage pipelines: float->fixed (fp2int path) and fixed->float (int2fp path).
- Used at the boundary between float-formatted sample files/interfaces and the fixed-point datapath.
- Chaining the fp2int output into the int2fp input must reproduce the original float for every in-range value.

Parameters:
- I_EXP, 8, exponent field width; bias = 2^(I_EXP-1)-1.
- I_MNT, 23, stored mantissa (fraction) width; hidden leading 1 implied.
- I_DATA, 32, float word width and fixed-point word width; must equal 1+I_EXP+I_MNT.
- R, 16, number of fraction bits in the fixed-point format (default Q16.16).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- enable  in  1  qualifies fp_in for conversion this cycle.
- fp_in  in  I_DATA  float input {sign, exp[I_EXP], mnt[I_MNT]}.
- int_out  out  I_DATA  signed fixed-point result, R fraction bits.
- int_valid  out  1  int_out holds a new result.
- int_enable  in  1  qualifies int_in for conversion this cycle.
- int_in  in  I_DATA  signed fixed-point input, R fraction bits.
- fp_out  out  I_DATA  float result.
- fp_valid  out  1  fp_out holds a new result.

Behaviour:
- Reset: when reset=0 at a rising edge, int_out=0, fp_out=0, int_valid=0 and fp_valid=0. Reset overrides enable. A conversion in flight is discarded.
- Latency: exactly 1 cycle per path.
  - enable sampled high at edge N -> int_out and int_valid=1 are visible after edge N.
  - int_enable behaves the same way for fp_out and fp_valid.
- Valid rules:
  - valid=0 on any cycle whose enable was low.
  - Data outputs hold their last value when enable is low.
  - Back-to-back enables give one result per cycle.
  - The two paths are fully independent, and simultaneous operation is allowed.
- fp2int arithmetic:
  - Value = (-1)^s * 1.mnt * 2^(exp-bias). Output = value*2^R, truncated toward zero, then two's-complemented if s=1.
  - Implemented as a barrel shift of {1,mnt} by (exp-bias+R-I_MNT): left if positive, right otherwise.
  - exp=0 (zero/denormal) -> 0.
  - Result magnitude below 2^-R -> 0, including -0 -> 0.
  - Positive overflow (value >= 2^(I_DATA-1-R)) or +inf -> 0x7FFF..FF.
  - Negative overflow (value < -2^(I_DATA-1-R)) or -inf -> 0x8000..00.
  - Exactly -2^(I_DATA-1-R) -> 0x8000..00 (not overflow).
  - NaN (exp all ones, mnt!=0) -> 0.
- int2fp arithmetic:
  - sign = int_in MSB; magnitude = |int_in|, computed in I_DATA+1 bits so 0x8000..00 is handled.
  - p = position of the leading 1 of the magnitude (priority encoder).
  - exp = p - R + bias.
  - mnt = the I_MNT bits below the leading 1, left-aligned; lower bits are truncated (round toward zero).
  - int_in=0 -> fp_out = +0 (all zeros).
  - Parameters must keep exp within 1..2^I_EXP-2 for all inputs; no inf/denormal output is produced.
- Round trip:
  - Any float whose value lies in the fixed-point range and whose LSB weight is >= 2^-R converts fp->int->fp bit-exactly.
  - Negative zero returns as +0.

Test Plan:
- Reset low for 2 cycles with enable=int_enable=1 -> all outputs 0 and both valids 0. Release reset -> first results appear 1 cycle later.
- fp_in=0x3F800000 (1.0) -> int_out=0x00010000. Feeding that to int_in -> fp_out=0x3F800000.
- fp_in=0xC0200000 (-2.5) -> int_out=0xFFFD8000 -> fp_out=0xC0200000. Check int_valid and fp_valid each go high exactly 1 cycle after their enable.
- Saturation:
  - fp_in=0x47800000 (65536.0) -> 0x7FFFFFFF.
  - fp_in=0xC7800000 -> 0x80000000.
  - fp_in=0x7F800000 (+inf) -> 0x7FFFFFFF.
  - NaN 0x7FC00000 -> 0.
  - fp_in=0x35800000 (2^-20) -> 0.
- int2fp edges:
  - int_in=0x7FFFFFFF -> 0x46FFFFFF (truncated).
  - int_in=0x80000000 -> 0xC7000000.
  - int_in=0x00000001 -> 0x37800000.
  - int_in=0 -> 0x00000000.
- Streaming: 100 random in-range floats on consecutive cycles, then enable low for 3 cycles.
  - Every looped-back fp_out equals its fp_in delayed by 2 cycles.
  - Valids drop while enable is low, and outputs hold.
